// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, 5-bit opcodes and the mul/div sequencer state encoding.
package alu_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;
    localparam logic [4:0] OP_AND = 5'b00010;
    localparam logic [4:0] OP_OR  = 5'b00011;
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } state_t;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then arithmetic shift of {A,Q,Q-1}.
module booth_step
    import alu_pkg::*;
(
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next,
    output logic             q_m1_next
);

    // A carries one guard bit so that subtracting M = -2^(WIDTH-1) cannot overflow.
    logic [WIDTH:0] sum;

    always_comb begin
        sum = a;
        case ({q[0], q_m1})
            2'b01:   sum = a + m;
            2'b10:   sum = a - m;
            default: sum = a;
        endcase
        a_next    = {sum[WIDTH], sum[WIDTH:1]};
        q_next    = {sum[0], q[WIDTH-1:1]};
        q_m1_next = q[0];
    end

endmodule

// File: rtl/muldiv_seq_unit.sv
// 33-clock signed multiply (Booth radix-2) / divide (restoring on magnitudes) engine with start/busy/done handshake.
module muldiv_seq_unit
    import alu_pkg::*;
#(
    parameter logic [4:0] MUL_OP = OP_MUL,
    parameter logic [4:0] DIV_OP = OP_DIV
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               start,
    input  logic [4:0]         opcode,
    input  logic [WIDTH-1:0]   A_reg,
    input  logic [WIDTH-1:0]   B_reg,
    output logic [2*WIDTH-1:0] result,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero
);

    state_t             state_q, state_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH:0]     m_q, m_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   a_lat_q, a_lat_d;
    logic               qm1_q, qm1_d;
    logic               is_div_q, is_div_d;
    logic               a_neg_q, a_neg_d;
    logic               b_neg_q, b_neg_d;
    logic               dvz_q, dvz_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] result_d;
    logic               busy_d, done_d, div_by_zero_d;

    logic [WIDTH:0]     booth_a;
    logic [WIDTH-1:0]   booth_q;
    logic               booth_qm1;
    logic               accept;
    logic               op_is_div;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   diff;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    booth_step u_booth (
        .a         (acc_q),
        .q         (q_q),
        .q_m1      (qm1_q),
        .m         (m_q),
        .a_next    (booth_a),
        .q_next    (booth_q),
        .q_m1_next (booth_qm1)
    );

    // Operand conditioning, divide trial subtraction and sign fix-up.
    always_comb begin
        op_is_div = (opcode == DIV_OP);
        accept    = start && ((opcode == MUL_OP) || op_is_div);
        a_mag     = A_reg[WIDTH-1] ? -A_reg : A_reg;
        b_mag     = B_reg[WIDTH-1] ? -B_reg : B_reg;
        rem_sh    = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        diff      = {1'b0, rem_sh} - {2'b00, m_q[WIDTH-1:0]};
        quo_fix   = (a_neg_q ^ b_neg_q) ? -q_q : q_q;
        rem_fix   = a_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        m_d           = m_q;
        q_d           = q_q;
        a_lat_d       = a_lat_q;
        qm1_d         = qm1_q;
        is_div_d      = is_div_q;
        a_neg_d       = a_neg_q;
        b_neg_d       = b_neg_q;
        dvz_d         = dvz_q;
        cnt_d         = cnt_q;
        result_d      = result;
        busy_d        = busy;
        done_d        = 1'b0;
        div_by_zero_d = div_by_zero;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d       = CALC;
                    busy_d        = 1'b1;
                    div_by_zero_d = 1'b0;
                    cnt_d         = '0;
                    acc_d         = '0;
                    qm1_d         = 1'b0;
                    is_div_d      = op_is_div;
                    a_neg_d       = A_reg[WIDTH-1];
                    b_neg_d       = B_reg[WIDTH-1];
                    a_lat_d       = A_reg;
                    dvz_d         = op_is_div && (B_reg == '0);
                    if (op_is_div) begin
                        q_d = a_mag;
                        m_d = {1'b0, b_mag};
                    end else begin
                        q_d = B_reg;
                        m_d = {A_reg[WIDTH-1], A_reg};
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (is_div_q) begin
                    // Negative trial difference means restore: keep the shifted remainder, quotient bit 0.
                    if (diff[WIDTH+1]) begin
                        acc_d = rem_sh;
                        q_d   = {q_q[WIDTH-2:0], 1'b0};
                    end else begin
                        acc_d = diff[WIDTH:0];
                        q_d   = {q_q[WIDTH-2:0], 1'b1};
                    end
                end else begin
                    acc_d = booth_a;
                    q_d   = booth_q;
                    qm1_d = booth_qm1;
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    result_d = {acc_q[WIDTH-1:0], q_q};
                end else if (dvz_q) begin
                    result_d      = {a_lat_q, {WIDTH{1'b1}}};
                    div_by_zero_d = 1'b1;
                end else begin
                    result_d = {rem_fix, quo_fix};
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            m_q         <= '0;
            q_q         <= '0;
            a_lat_q     <= '0;
            qm1_q       <= 1'b0;
            is_div_q    <= 1'b0;
            a_neg_q     <= 1'b0;
            b_neg_q     <= 1'b0;
            dvz_q       <= 1'b0;
            cnt_q       <= '0;
            result      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            m_q         <= m_d;
            q_q         <= q_d;
            a_lat_q     <= a_lat_d;
            qm1_q       <= qm1_d;
            is_div_q    <= is_div_d;
            a_neg_q     <= a_neg_d;
            b_neg_q     <= b_neg_d;
            dvz_q       <= dvz_d;
            cnt_q       <= cnt_d;
            result      <= result_d;
            busy        <= busy_d;
            done        <= done_d;
            div_by_zero <= div_by_zero_d;
        end
    end

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Directed bench for muldiv_seq_unit: vector table plus handshake, divide-by-zero and abort sequences.
module tb_muldiv_seq_unit;

    localparam logic [4:0] MUL = 5'b01111;
    localparam logic [4:0] DIV = 5'b10000;
    localparam logic [4:0] ADD = 5'b00000;

    logic        clk;
    logic        clear;
    logic        start;
    logic [4:0]  opcode;
    logic [31:0] A_reg;
    logic [31:0] B_reg;
    logic [63:0] result;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int pass_cnt = 0;
    int total    = 0;

    muldiv_seq_unit dut (
        .clk         (clk),
        .clear       (clear),
        .start       (start),
        .opcode      (opcode),
        .A_reg       (A_reg),
        .B_reg       (B_reg),
        .result      (result),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  op;
        logic [63:0] exp_res;
        logic        exp_dbz;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drive one request, clocked in on the next rising edge; returns #1 after that edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        A_reg  = a;
        B_reg  = b;
        opcode = op;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    // Count edges until done is seen, bounded; returns #1 after the edge that raised done.
    task automatic wait_done(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int  cyc;
        bit  ok;
        bit  seen;

        vecs[0]  = '{32'h00000007, 32'hFFFFFFFD, MUL, 64'hFFFFFFFF_FFFFFFEB, 1'b0};
        vecs[1]  = '{32'h80000000, 32'h80000000, MUL, 64'h40000000_00000000, 1'b0};
        vecs[2]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, MUL, 64'h3FFFFFFF_00000001, 1'b0};
        vecs[3]  = '{32'h00000006, 32'h00000007, MUL, 64'h00000000_0000002A, 1'b0};
        vecs[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, MUL, 64'h00000000_00000001, 1'b0};
        vecs[5]  = '{32'h00000011, 32'hFFFFFFFB, DIV, 64'h00000002_FFFFFFFD, 1'b0};
        vecs[6]  = '{32'hFFFFFFEF, 32'h00000005, DIV, 64'hFFFFFFFE_FFFFFFFD, 1'b0};
        vecs[7]  = '{32'h80000000, 32'hFFFFFFFF, DIV, 64'h00000000_80000000, 1'b0};
        vecs[8]  = '{32'hFFFFFFEF, 32'hFFFFFFFB, DIV, 64'hFFFFFFFE_00000003, 1'b0};
        vecs[9]  = '{32'h00000064, 32'h00000007, DIV, 64'h00000002_0000000E, 1'b0};
        vecs[10] = '{32'h00000064, 32'h00000000, DIV, 64'h00000064_FFFFFFFF, 1'b1};
        vecs[11] = '{32'h00000003, 32'h00000005, MUL, 64'h00000000_0000000F, 1'b0};

        clear = 1'b1; start = 1'b0; opcode = ADD; A_reg = '0; B_reg = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", result, 64'h0);
        check("reset_busy", 64'(busy), 64'h0);
        check("reset_done", 64'(done), 64'h0);
        check("reset_dbz", 64'(div_by_zero), 64'h0);
        clear = 1'b0;

        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].op);
            check($sformatf("v%0d_busy_accept", i), 64'(busy), 64'h1);
            wait_done(cyc, ok);
            check($sformatf("v%0d_latency", i), 64'(ok ? cyc : -1), 64'd33);
            check($sformatf("v%0d_busy_at_done", i), 64'(busy), 64'h0);
            check($sformatf("v%0d_result", i), result, vecs[i].exp_res);
            check($sformatf("v%0d_dbz", i), 64'(div_by_zero), 64'(vecs[i].exp_dbz));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_pulse", i), 64'(done), 64'h0);
        end

        // Divide by zero flag holds past done and clears on the next accepted start.
        start_op(32'h00000064, 32'h00000000, DIV);
        wait_done(cyc, ok);
        repeat (2) @(posedge clk);
        #1;
        check("dbz_held", 64'(div_by_zero), 64'h1);
        start_op(32'h00000002, 32'h00000002, MUL);
        check("dbz_cleared_on_start", 64'(div_by_zero), 64'h0);
        wait_done(cyc, ok);
        check("dbz_next_mul", result, 64'd4);

        // Unsupported opcode is ignored.
        start_op(32'h00000009, 32'h00000009, ADD);
        check("badop_busy", 64'(busy), 64'h0);
        repeat (3) @(posedge clk);
        #1;
        check("badop_no_done", 64'(done), 64'h0);
        check("badop_result_kept", result, 64'd4);

        // Second start mid-operation must not disturb the first.
        start_op(32'h00000006, 32'h00000007, MUL);
        repeat (5) @(posedge clk);
        #1;
        start_op(32'h00000003, 32'h00000003, DIV);
        wait_done(cyc, ok);
        check("midstart_latency", 64'(ok ? cyc + 6 : -1), 64'd33);
        check("midstart_result", result, 64'd42);
        repeat (3) @(posedge clk);
        #1;
        check("midstart_idle", 64'(busy), 64'h0);

        // Start presented in the done cycle is accepted; done is not re-raised.
        start_op(32'h00000005, 32'h00000005, MUL);
        wait_done(cyc, ok);
        check("donecyc_first", result, 64'd25);
        start_op(32'hFFFFFFF8, 32'h00000003, DIV);
        check("donecyc_busy", 64'(busy), 64'h1);
        check("donecyc_no_redone", 64'(done), 64'h0);
        wait_done(cyc, ok);
        check("donecyc_latency", 64'(ok ? cyc : -1), 64'd33);
        check("donecyc_result", result, 64'hFFFFFFFE_FFFFFFFE);

        // clear 10 clocks into a divide aborts everything.
        start_op(32'h00000064, 32'h00000007, DIV);
        repeat (9) @(posedge clk);
        #1;
        clear = 1'b1;
        start = 1'b1;
        opcode = MUL;
        @(posedge clk);
        #1;
        clear = 1'b0;
        start = 1'b0;
        check("abort_result", result, 64'h0);
        check("abort_busy", 64'(busy), 64'h0);
        check("abort_done", 64'(done), 64'h0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        check("abort_no_done", 64'(seen), 64'h0);
        start_op(32'h00000006, 32'h00000007, MUL);
        wait_done(cyc, ok);
        check("abort_next_latency", 64'(ok ? cyc : -1), 64'd33);
        check("abort_next_result", result, 64'd42);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
